bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the width of the request data path.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the width of the request tag.
REQ-003 Parameter RESP_BEATS, default 8, SHALL set the number of response beats per transaction (one 64-byte line).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 bid  in  2  SHALL be the per-master bus bids; bit0 is the instruction cache and bit1 is the data cache.
REQ-007 grant  out  2  SHALL be the per-master grants, registered and one-hot or zero.
REQ-008 m_reqcyc  in  2  SHALL be the per-master request-valid inputs.
REQ-009 m1_req / m2_req  in  BUS_DATA_WIDTH  SHALL be the request data for master 0 and master 1.
REQ-010 m1_reqtag / m2_reqtag  in  BUS_TAG_WIDTH  SHALL be the request tags for master 0 and master 1.
REQ-011 m_reqack  out  2  SHALL be bus_reqack routed to the granted master.
REQ-012 m_respcyc  out  2  SHALL be bus_respcyc routed to the granted master.
REQ-013 m_respack  in  2  SHALL be the per-master response acknowledges.
REQ-014 bus_reqcyc, bus_req, bus_reqtag, bus_respack  out  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH/1  SHALL be the muxed bus-side request and acknowledge signals.
REQ-015 bus_reqack, bus_respcyc  in  1  SHALL be the bus-side handshake inputs.

Function
REQ-016 FSM states SHALL be IDLE, REQ and RESP, with grant all-zero in IDLE and exactly one bit set in REQ and RESP.
REQ-017 IDLE SHALL arbitrate as follows:
- If any bid bit is set, the next state SHALL be REQ with the chosen grant bit set at the next edge (grant latency of 1 cycle).
- If only one bit is set, that master SHALL be chosen.
- If both bits are set, the master not served last (round-robin pointer) SHALL be chosen.
REQ-018 On entering REQ, the round-robin pointer SHALL update to the granted master.
REQ-019 In REQ and RESP the bus-side signals SHALL be driven as follows:
- bus_reqcyc, bus_req and bus_reqtag SHALL be combinationally muxed from the granted master.
- bus_respack SHALL be driven from the granted master's m_respack.
- In IDLE all four SHALL be driven to 0.
REQ-020 For the non-granted master, and in IDLE, m_reqack and m_respcyc SHALL be 0.
REQ-021 The arbiter SHALL count bus_reqcyc and bus_reqack handshakes in REQ.
- REQ to RESP SHALL occur when granted m_reqcyc is low and at least one handshake has been counted.
REQ-022 If the granted master drops its bid in REQ before any handshake, the FSM SHALL return to IDLE (abort) and the pointer SHALL keep its update.
REQ-023 In RESP, a beat counter SHALL increment on each cycle with bus_respcyc and granted m_respack both high.
- The counter SHALL be clog2(RESP_BEATS)+1 bits, with no wrap before the terminal count.
REQ-024 On the beat that brings the counter to RESP_BEATS, the FSM SHALL go to IDLE and grant SHALL clear at that edge.
- Each transaction SHALL be followed by at least one IDLE cycle.
REQ-025 bid changes during RESP SHALL be ignored; the transaction SHALL complete.
REQ-026 bus_respcyc high without m_respack SHALL stall the counter (backpressure), with no timeout.

Reset
REQ-027 While reset is low the following SHALL hold immediately and asynchronously:
- State SHALL be IDLE.
- grant, all counters and all m_* outputs SHALL be 0.
- bus_reqcyc, bus_req, bus_reqtag and bus_respack SHALL be 0.
- The pointer SHALL favour master 0 on the first tie.
REQ-028 A reset assertion mid-transaction SHALL abandon the transaction; after release the FSM SHALL start from IDLE with no residual grant.

Verification
REQ-029 Bid=01 at cycle 0 -> grant=01 at cycle 1, bus_req equals m1_req, one handshake, then 8 acked beats -> grant=00 on the cycle after the 8th beat.
REQ-030 Bid=11 held after reset -> grants alternate 01, 10, 01 across three transactions, with one IDLE cycle between each.
REQ-031 Data cache in RESP with bus_respcyc=1 and m_respack=0 for 5 cycles -> beat count frozen, grant=10 held, completion after 8 acked beats.
REQ-032 Granted master drops bid in REQ before bus_reqack -> IDLE next cycle, grant=00, and the other master wins the next tie.
REQ-033 reset driven low at beat 4 of RESP -> grant=00 and all bus outputs 0 without waiting for a clock edge; after release, bid=10 -> grant=10 one cycle later.
REQ-034 Non-granted master observes bus_respcyc=1 during another master's RESP -> its m_respcyc stays 0 throughout.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter (icache = master 0, dcache = master 1).
// Grants one master for a request phase followed by a fixed-length response burst.
module bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int RESP_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                bid,
    output logic [1:0]                grant,
    input  logic [1:0]                m_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_DATA_WIDTH-1:0] m2_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  m2_reqtag,
    output logic [1:0]                m_reqack,
    output logic [1:0]                m_respcyc,
    input  logic [1:0]                m_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc
);

    localparam int CW = $clog2(RESP_BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(RESP_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [1:0]    hs_q, hs_d;
    logic [CW-1:0] beat_q, beat_d;

    logic [1:0] pick;
    logic       g_bid;
    logic       g_reqcyc;
    logic       g_respack;
    logic       hs_now;
    logic       beat_now;

    assign g_bid     = |(bid & grant_q);
    assign g_reqcyc  = |(m_reqcyc & grant_q);
    assign g_respack = |(m_respack & grant_q);
    assign hs_now    = g_reqcyc & bus_reqack;
    assign beat_now  = bus_respcyc & g_respack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            hs_q    <= 2'b00;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hs_q    <= hs_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hs_d    = hs_q;
        beat_d  = beat_q;
        pick    = 2'b00;
        unique case (state_q)
            IDLE: begin
                hs_d   = 2'b00;
                beat_d = '0;
                if (bid == 2'b11) begin
                    pick = last_q ? 2'b01 : 2'b10;
                end else begin
                    pick = bid;
                end
                if (|bid) begin
                    state_d = REQ;
                    grant_d = pick;
                    last_d  = pick[1];
                end
            end
            REQ: begin
                if (hs_now && hs_q != 2'b11) begin
                    hs_d = hs_q + 2'b01;
                end
                // Abort only if nothing has been handed to the bus yet
                if (!g_bid && hs_q == 2'b00 && !hs_now) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else if (!g_reqcyc && hs_q != 2'b00) begin
                    state_d = RESP;
                    beat_d  = '0;
                end
            end
            RESP: begin
                if (beat_now) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Muxes key off grant_q, which is zero in IDLE and clears asynchronously on reset
    assign grant       = grant_q;
    assign bus_reqcyc  = g_reqcyc;
    assign bus_respack = g_respack;
    assign bus_req     = ({BUS_DATA_WIDTH{grant_q[0]}} & m1_req)
                       | ({BUS_DATA_WIDTH{grant_q[1]}} & m2_req);
    assign bus_reqtag  = ({BUS_TAG_WIDTH{grant_q[0]}} & m1_reqtag)
                       | ({BUS_TAG_WIDTH{grant_q[1]}} & m2_reqtag);
    assign m_reqack    = grant_q & {2{bus_reqack}};
    assign m_respcyc   = grant_q & {2{bus_respcyc}};

endmodule
